// File: rtl/adder_2_reg.sv
// adder_2_reg: two-operand registered adder, leaf element of partial-sum trees.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, clears all outputs
//   in_valid  in   a/b carry a valid operand pair this cycle
//   a, b      in   WIDTH-bit operands (sign-agnostic)
//   out_valid out  registered copy of in_valid
//   out       out  registered sum (wrapping, or signed-saturating when SATURATE=1)
//   carry     out  registered unsigned carry-out of a+b
//   ovf       out  registered signed-overflow flag
//
// Latency is exactly one cycle. Data registers only load on in_valid, so an
// idle cycle holds the last result and keeps unknown operands out of the
// output path.
module adder_2_reg #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             ovf_d;

  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  assign sum_full = {1'b0, a} + {1'b0, b};

  always_comb begin
    carry_d = sum_full[WIDTH];
    // Signed overflow: operands agree in sign but the result does not.
    ovf_d   = (a[MSB] == b[MSB]) && (sum_full[MSB] != a[MSB]);
    sum_d   = sum_full[WIDTH-1:0];
    if (SATURATE && ovf_d) begin
      sum_d = a[MSB] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_2_reg.sv
// tb_adder_2_reg: bench for adder_2_reg. A wrapping and a saturating instance
// share one operand stream; a five-level tree of wrapping instances sums
// sixteen operand pairs. Expected results are queued when driven and popped
// when out_valid is seen.
module tb_adder_2_reg;

  typedef struct packed {
    logic [31:0] o;
    logic        c;
    logic        f;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;

  logic        w_valid, w_carry, w_ovf;
  logic [31:0] w_out;
  logic        s_valid, s_carry, s_ovf;
  logic [31:0] s_out;

  logic        t_v;
  logic [31:0] t_a, t_b;
  logic        n_v [31];
  logic [31:0] n_o [31];
  logic        n_c [31];
  logic        n_f [31];

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t last_w, last_s;
  logic prev_v;

  int n_tests = 0;
  int n_fail  = 0;

  adder_2_reg #(.WIDTH(32), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(w_valid), .out(w_out), .carry(w_carry), .ovf(w_ovf)
  );

  adder_2_reg #(.WIDTH(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(s_valid), .out(s_out), .carry(s_carry), .ovf(s_ovf)
  );

  // Tree nodes: level k occupies indices 32-(32>>k) .. 32-(32>>k)+(16>>k)-1.
  for (genvar g = 0; g < 16; g++) begin : g_l0
    adder_2_reg #(.WIDTH(32), .SATURATE(1'b0)) u_node (
      .clk(clk), .rst_n(rst_n), .in_valid(t_v), .a(t_a), .b(t_b),
      .out_valid(n_v[g]), .out(n_o[g]), .carry(n_c[g]), .ovf(n_f[g])
    );
  end

  for (genvar k = 1; k < 5; k++) begin : g_lvl
    for (genvar j = 0; j < (16 >> k); j++) begin : g_node
      localparam int DST = 32 - (32 >> k) + j;
      localparam int SRC = 32 - (32 >> (k - 1)) + 2 * j;
      adder_2_reg #(.WIDTH(32), .SATURATE(1'b0)) u_node (
        .clk(clk), .rst_n(rst_n), .in_valid(n_v[SRC]),
        .a(n_o[SRC]), .b(n_o[SRC+1]),
        .out_valid(n_v[DST]), .out(n_o[DST]), .carry(n_c[DST]), .ovf(n_f[DST])
      );
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit sat);
    logic [32:0] s;
    exp_t e;
    s   = {1'b0, x} + {1'b0, y};
    e.c = s[32];
    e.f = (x[31] == y[31]) && (s[31] != x[31]);
    e.o = s[31:0];
    if (sat && e.f) e.o = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return e;
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic v);
    in_valid = v;
    prev_v   = v;
    if (v) begin
      a = x;
      b = y;
      q_w.push_back(model(x, y, 1'b0));
      q_s.push_back(model(x, y, 1'b1));
    end else begin
      a = 'x;
      b = 'x;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd7;
    t_v = 1'b0; t_a = '0; t_b = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({w_valid, w_out, w_carry, w_ovf, s_valid, s_out, s_carry, s_ovf} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: wrap v=%b o=%h c=%b f=%b sat v=%b o=%h, required all 0",
                 i, w_valid, w_out, w_carry, w_ovf, s_valid, s_out);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (w_valid !== 1'b1 || w_out !== 32'd12 || w_carry !== 1'b0 || w_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: v=%b o=%h c=%b f=%b, required v=1 o=0000000c c=0 f=0",
               w_valid, w_out, w_carry, w_ovf);
    end
    last_w = '{o: 32'd12, c: 1'b0, f: 1'b0};
    last_s = last_w;
    drive('0, '0, 1'b0);
  endtask

  task automatic test_basic();
    exp_t ew, es;
    @(negedge clk);
    drive(32'h1, 32'h2, 1'b1);
    @(negedge clk);
    n_tests++;
    if (w_valid !== 1'b1 || w_out !== 32'h3 || q_w.size() == 0) begin
      n_fail++;
      $display("FAIL basic_latency: v=%b o=%h, required v=1 o=00000003", w_valid, w_out);
    end else begin
      ew = q_w.pop_front(); es = q_s.pop_front();
      n_tests++;
      if ({s_out, s_carry, s_ovf} !== es) begin
        n_fail++;
        $display("FAIL basic_sat: o=%h c=%b f=%b, required o=%h c=%b f=%b",
                 s_out, s_carry, s_ovf, es.o, es.c, es.f);
      end
      last_w = ew; last_s = es;
    end
    drive('0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (w_valid !== 1'b0 || w_out !== 32'h3 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: v=%b o=%h, required v=0 o=00000003", w_valid, w_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    exp_t want [3];
    exp_t ew, es;
    xa[0] = 32'hFFFF_FFFF; xb[0] = 32'h1;         want[0] = '{o: 32'h0,         c: 1'b1, f: 1'b0};
    xa[1] = 32'h7FFF_FFFF; xb[1] = 32'h1;         want[1] = '{o: 32'h8000_0000, c: 1'b0, f: 1'b1};
    xa[2] = 32'h8000_0000; xb[2] = 32'h8000_0000; want[2] = '{o: 32'h0,         c: 1'b1, f: 1'b1};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (w_valid !== 1'b1 || q_w.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_valid[%0d]: v=%b, required 1", i - 1, w_valid);
        end else begin
          ew = q_w.pop_front(); es = q_s.pop_front();
          n_tests++;
          if ({w_out, w_carry, w_ovf} !== want[i-1]) begin
            n_fail++;
            $display("FAIL wrap[%0d]: o=%h c=%b f=%b, required o=%h c=%b f=%b", i - 1,
                     w_out, w_carry, w_ovf, want[i-1].o, want[i-1].c, want[i-1].f);
          end
          n_tests++;
          if ({s_out, s_carry, s_ovf} !== es) begin
            n_fail++;
            $display("FAIL wrap_satdut[%0d]: o=%h c=%b f=%b, required o=%h c=%b f=%b", i - 1,
                     s_out, s_carry, s_ovf, es.o, es.c, es.f);
          end
          last_w = ew; last_s = es;
        end
      end
      if (i < 3) drive(xa[i], xb[i], 1'b1);
      else       drive('0, '0, 1'b0);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    exp_t want [3];
    exp_t ew, es;
    xa[0] = 32'h7FFF_FFFF; xb[0] = 32'h1;         want[0] = '{o: 32'h7FFF_FFFF, c: 1'b0, f: 1'b1};
    xa[1] = 32'h8000_0000; xb[1] = 32'hFFFF_FFFF; want[1] = '{o: 32'h8000_0000, c: 1'b1, f: 1'b1};
    xa[2] = 32'hFFFF_FFFE; xb[2] = 32'h1;         want[2] = '{o: 32'hFFFF_FFFF, c: 1'b0, f: 1'b0};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (s_valid !== 1'b1 || q_s.size() == 0) begin
          n_fail++;
          $display("FAIL sat_valid[%0d]: v=%b, required 1", i - 1, s_valid);
        end else begin
          ew = q_w.pop_front(); es = q_s.pop_front();
          n_tests++;
          if ({s_out, s_carry, s_ovf} !== want[i-1]) begin
            n_fail++;
            $display("FAIL sat[%0d]: o=%h c=%b f=%b, required o=%h c=%b f=%b", i - 1,
                     s_out, s_carry, s_ovf, want[i-1].o, want[i-1].c, want[i-1].f);
          end
          n_tests++;
          if ({w_out, w_carry, w_ovf} !== ew) begin
            n_fail++;
            $display("FAIL sat_wrapdut[%0d]: o=%h c=%b f=%b, required o=%h c=%b f=%b", i - 1,
                     w_out, w_carry, w_ovf, ew.o, ew.c, ew.f);
          end
          last_w = ew; last_s = es;
        end
      end
      if (i < 3) drive(xa[i], xb[i], 1'b1);
      else       drive('0, '0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [4];
    logic [31:0] xb [4];
    exp_t want [4];
    exp_t ew, es;
    xa[0] = 32'h1;         xb[0] = 32'h2;         want[0] = '{o: 32'h3,         c: 1'b0, f: 1'b0};
    xa[1] = 32'h3;         xb[1] = 32'h4;         want[1] = '{o: 32'h7,         c: 1'b0, f: 1'b0};
    xa[2] = 32'h10;        xb[2] = 32'h20;        want[2] = '{o: 32'h30,        c: 1'b0, f: 1'b0};
    xa[3] = 32'hFFFF_FFFF; xb[3] = 32'hFFFF_FFFF; want[3] = '{o: 32'hFFFF_FFFE, c: 1'b1, f: 1'b0};
    for (int sw = 0; sw < 2; sw++) begin
      for (int i = 0; i <= 4; i++) begin
        @(negedge clk);
        if (i > 0) begin
          n_tests++;
          if (w_valid !== 1'b1 || q_w.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_valid[%0d/%0d]: v=%b, required 1", sw, i - 1, w_valid);
          end else begin
            ew = q_w.pop_front(); es = q_s.pop_front();
            n_tests++;
            if ({w_out, w_carry, w_ovf} !== want[i-1] || {s_out, s_carry, s_ovf} !== es) begin
              n_fail++;
              $display("FAIL b2b[%0d/%0d]: o=%h c=%b f=%b sat o=%h, required o=%h c=%b f=%b sat o=%h",
                       sw, i - 1, w_out, w_carry, w_ovf, s_out,
                       want[i-1].o, want[i-1].c, want[i-1].f, es.o);
            end
            last_w = ew; last_s = es;
          end
        end
        if (i < 4) begin
          if (sw == 0) drive(xa[i], xb[i], 1'b1);
          else         drive(xb[i], xa[i], 1'b1);
        end else begin
          drive('0, '0, 1'b0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [6];
    logic [31:0] x, y;
    exp_t ew, es;
    logic exp_v;
    corner[0] = 32'h0;         corner[1] = 32'h1;         corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF; corner[5] = 32'hFFFF_FFFE;
    for (int i = 0; i <= 300; i++) begin
      exp_v = prev_v;
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (w_valid !== exp_v || s_valid !== exp_v) begin
          n_fail++;
          $display("FAIL rnd_valid[%0d]: v=%b/%b, required %b", i, w_valid, s_valid, exp_v);
        end
        if (w_valid === 1'b1) begin
          if (q_w.size() == 0) begin
            n_fail++;
            $display("FAIL rnd_unexpected[%0d]: out_valid=1, required no result pending", i);
          end else begin
            ew = q_w.pop_front(); es = q_s.pop_front();
            n_tests++;
            if ({w_out, w_carry, w_ovf} !== ew || {s_out, s_carry, s_ovf} !== es) begin
              n_fail++;
              $display("FAIL rnd[%0d]: wrap %h/%b/%b sat %h/%b/%b, required wrap %h/%b/%b sat %h/%b/%b",
                       i, w_out, w_carry, w_ovf, s_out, s_carry, s_ovf,
                       ew.o, ew.c, ew.f, es.o, es.c, es.f);
            end
            last_w = ew; last_s = es;
          end
        end else begin
          n_tests++;
          if ({w_out, w_carry, w_ovf} !== last_w || {s_out, s_carry, s_ovf} !== last_s) begin
            n_fail++;
            $display("FAIL rnd_hold[%0d]: wrap %h sat %h, required wrap %h sat %h",
                     i, w_out, s_out, last_w.o, last_s.o);
          end
        end
      end
      if (i < 300 && $urandom_range(0, 9) < 7) begin
        x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
        y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
        drive(x, y, 1'b1);
      end else begin
        drive('0, '0, 1'b0);
      end
    end
    @(negedge clk);
    n_tests++;
    if (q_w.size() != 0 || q_s.size() != 0 || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_drain: pending=%0d/%0d v=%b, required 0/0 v=0",
               q_w.size(), q_s.size(), w_valid);
    end
  endtask

  task automatic test_tree();
    @(negedge clk);
    t_a = 32'd1; t_b = 32'd2; t_v = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        t_v = 1'b0; t_a = 'x; t_b = 'x;
      end
      n_tests++;
      if (n_v[30] !== (c == 5)) begin
        n_fail++;
        $display("FAIL tree_valid[cycle %0d]: v=%b, required %b", c, n_v[30], (c == 5));
      end
      if (c == 5) begin
        n_tests++;
        if (n_o[30] !== 32'h30 || n_c[30] !== 1'b0 || n_f[30] !== 1'b0) begin
          n_fail++;
          $display("FAIL tree_sum: o=%h c=%b f=%b, required o=00000030 c=0 f=0",
                   n_o[30], n_c[30], n_f[30]);
        end
      end
    end
  endtask

  task automatic test_tree_reset();
    int bad;
    @(negedge clk);
    t_a = 32'd1; t_b = 32'd2; t_v = 1'b1;
    @(negedge clk);
    t_v = 1'b0; t_a = 'x; t_b = 'x;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    bad = 0;
    for (int n = 0; n < 31; n++)
      if (n_v[n] !== 1'b0 || n_o[n] !== '0 || n_c[n] !== 1'b0 || n_f[n] !== 1'b0) bad++;
    n_tests++;
    if (bad != 0 || {w_valid, w_out, w_carry, w_ovf} !== '0) begin
      n_fail++;
      $display("FAIL tree_async_clear: %0d nodes nonzero, wrap o=%h, required 0 nodes and o=0",
               bad, w_out);
    end
    #4 rst_n = 1'b1;
    last_w = '0; last_s = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bad = 0;
      for (int n = 0; n < 31; n++)
        if (n_v[n] !== 1'b0 || n_o[n] !== '0 || n_c[n] !== 1'b0 || n_f[n] !== 1'b0) bad++;
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL tree_after_reset[cycle %0d]: %0d nodes nonzero (final v=%b o=%h), required 0",
                 c, bad, n_v[30], n_o[30]);
      end
    end
  endtask

  initial begin
    prev_v = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_random();
    test_tree();
    test_tree_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
